// File: rtl/delay_meter_pkg.sv
// Shared types and default sizing for the gate-delay measuring block.
package delay_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } state_t;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TIMEOUT     = 200;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/delay_meter_if.sv
// Controller / measured-path side of the delay meter.
// master = test controller plus the measured path (drives start, resp);
// slave  = the meter itself.
interface delay_meter_if #(
    parameter int CNT_W = delay_meter_pkg::DEF_CNT_W
);
    logic             start;
    logic             resp;
    logic             stim;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] delay_out;

    modport master (
        output start, resp,
        input  stim, busy, done, timeout, delay_out
    );

    modport slave (
        input  start, resp,
        output stim, busy, done, timeout, delay_out
    );
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for bringing an asynchronous level into clk.
// Cleared asynchronously so the chain comes out of reset at a known 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/delay_meter.sv
// Launches an edge on stim, counts clk edges until the synchronised
// response changes, and reports the count (or a timeout).
// The reported count includes the synchroniser latency (SYNC_STAGES+1 for a
// zero-delay loopback); removing that offset is left to software.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    delay_meter_if.slave mif
);

    if (TIMEOUT < 2 || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_timeout
        $error("delay_meter: TIMEOUT must be in [2, 2**CNT_W-1]");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("delay_meter: SYNC_STAGES must be >= 2");
    end

    // One extra bit so the timeout compare sees cnt+1 without wrapping
    localparam logic [CNT_W:0] TO_V = TIMEOUT[CNT_W:0];

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W:0]   cnt_inc;
    logic             stim_q, stim_nxt;
    logic             ref_lvl, ref_nxt;
    logic             done_q, done_nxt;
    logic             tout_q, tout_nxt;
    logic [CNT_W-1:0] dly_q, dly_nxt;
    logic             resp_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_resp_sync (
        .clk (clk),
        .rst (rst),
        .d   (mif.resp),
        .q   (resp_s)
    );

    assign cnt_inc = {1'b0, cnt} + 1'b1;

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            stim_q  <= 1'b0;
            ref_lvl <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            dly_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stim_q  <= stim_nxt;
            ref_lvl <= ref_nxt;
            done_q  <= done_nxt;
            tout_q  <= tout_nxt;
            dly_q   <= dly_nxt;
        end
    end

    // Next-state: launch from any idle state, then watch for the response edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stim_nxt  = stim_q;
        ref_nxt   = ref_lvl;
        done_nxt  = done_q;
        tout_nxt  = tout_q;
        dly_nxt   = dly_q;
        case (state)
            WAIT: begin
                // Detection wins over timeout when both land on the same edge
                if (resp_s != ref_lvl) begin
                    dly_nxt   = cnt_inc[CNT_W-1:0];
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (cnt_inc == TO_V) begin
                    dly_nxt   = TO_V[CNT_W-1:0];
                    tout_nxt  = 1'b1;
                    state_nxt = TOUT;
                end else begin
                    cnt_nxt   = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                // IDLE, DONE, TOUT: a start launches the opposite-polarity edge
                if (mif.start) begin
                    stim_nxt  = ~stim_q;
                    cnt_nxt   = '0;
                    ref_nxt   = resp_s;
                    done_nxt  = 1'b0;
                    tout_nxt  = 1'b0;
                    state_nxt = WAIT;
                end
            end
        endcase
    end

    assign mif.stim      = stim_q;
    assign mif.busy      = (state == WAIT);
    assign mif.done      = done_q;
    assign mif.timeout   = tout_q;
    assign mif.delay_out = dly_q;

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: gate-delay paths, timeout, async reset, back-to-back
// runs and randomized path delays, checked against a latency formula model.
module tb_delay_meter;

    localparam int CNT_W = 8;
    localparam int TMO   = 8;
    localparam int SYNC  = 2;
    localparam int TCLK  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nfail = 0;
    int   mode = 1;   // 0 tied low, 1 loopback, 2 and/or 9, 3 and/or 15, 4 variable
    int   vdly = 1;
    logic exp_stim = 1'b0;

    delay_meter_if #(.CNT_W(CNT_W)) mif ();

    delay_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TMO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    always #5 clk = ~clk;

    // Measured paths: AND feeding OR, side inputs held so stim propagates
    logic en_a = 1'b1;
    logic en_o = 1'b0;
    logic a9, p9, a15, p15;
    logic pv = 1'b0;
    assign #5 a9  = mif.stim & en_a;
    assign #4 p9  = a9 | en_o;
    assign #7 a15 = mif.stim & en_a;
    assign #8 p15 = a15 | en_o;

    // Variable-delay path for randomized runs
    always begin
        @(mif.stim);
        #(vdly);
        pv = mif.stim;
    end

    always_comb begin
        case (mode)
            0:       mif.resp = 1'b0;
            1:       mif.resp = mif.stim;
            2:       mif.resp = p9;
            3:       mif.resp = p15;
            default: mif.resp = pv;
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected count for a path of delay d (d<0: response never arrives)
    function automatic int model_raw(input int d);
        if (d < 0)  return 1000;
        if (d == 0) return SYNC + 1;
        return SYNC + 1 + (d + TCLK - 1) / TCLK - 1;
    endfunction

    task automatic measure(input int d, input string tag);
        int raw, exp_d, cyc;
        bit exp_done;
        raw      = model_raw(d);
        exp_done = (raw <= TMO);
        exp_d    = exp_done ? raw : TMO;
        exp_stim = ~exp_stim;
        @(negedge clk); mif.start = 1'b1;
        @(negedge clk); mif.start = 1'b0;
        cyc = 0;
        while (mif.busy && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, cyc, exp_d);
        chk({tag, ".busy"}, int'(mif.busy), 0);
        chk({tag, ".done"}, int'(mif.done), int'(exp_done));
        chk({tag, ".timeout"}, int'(mif.timeout), int'(!exp_done));
        chk({tag, ".delay_out"}, int'(mif.delay_out), exp_d);
        chk({tag, ".stim"}, int'(mif.stim), int'(exp_stim));
    endtask

    initial begin
        int toggles, dones, cyc, k, r, d;
        logic prev;
        mif.start = 1'b0;
        idle(3);
        chk("rst.stim", int'(mif.stim), 0);
        chk("rst.busy", int'(mif.busy), 0);
        chk("rst.done", int'(mif.done), 0);
        chk("rst.timeout", int'(mif.timeout), 0);
        chk("rst.delay_out", int'(mif.delay_out), 0);
        rst = 1'b0;
        idle(4);

        // Zero-delay loopback
        measure(0, "loop0");
        idle(4);

        // AND/OR path, rising then falling run
        mode = 2; idle(6);
        measure(9, "andor9_rise");
        idle(6);
        measure(9, "andor9_fall");
        idle(6);
        mode = 3; idle(6);
        measure(15, "andor15");
        idle(6);

        // Response never arrives, then recover with loopback
        mode = 0; idle(6);
        measure(-1, "tout");
        idle(3);
        mode = 1; idle(6);
        measure(0, "after_tout");
        idle(4);

        // start pulses during WAIT must not relaunch
        mode = 0; idle(6);
        exp_stim = ~exp_stim;
        @(negedge clk); mif.start = 1'b1;
        @(negedge clk); mif.start = 1'b0;
        repeat (3) begin
            @(negedge clk); mif.start = 1'b1;
            @(negedge clk); mif.start = 1'b0;
            chk("ign.stim", int'(mif.stim), int'(exp_stim));
        end
        cyc = 0;
        while (mif.busy && cyc < 300) begin cyc++; @(negedge clk); end
        chk("ign.timeout", int'(mif.timeout), 1);
        chk("ign.delay_out", int'(mif.delay_out), TMO);
        chk("ign.stim_end", int'(mif.stim), int'(exp_stim));

        // Asynchronous reset in the middle of WAIT
        mode = 1; idle(6);
        measure(0, "pre_rst");
        mode = 0; idle(6);
        @(negedge clk); mif.start = 1'b1;
        @(negedge clk); mif.start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst.stim", int'(mif.stim), 0);
        chk("mid_rst.busy", int'(mif.busy), 0);
        chk("mid_rst.done", int'(mif.done), 0);
        chk("mid_rst.delay_out", int'(mif.delay_out), 0);
        #2 rst = 1'b0;
        exp_stim = 1'b0;
        mode = 1; idle(6);
        measure(0, "post_rst");
        idle(4);

        // start held high: one relaunch per DONE visit
        toggles = 0; dones = 0;
        prev = mif.stim;
        @(negedge clk); mif.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.stim != prev) toggles++;
            prev = mif.stim;
            if (mif.done) begin
                dones++;
                chk("held.delay_out", int'(mif.delay_out), SYNC + 1);
            end
        end
        mif.start = 1'b0;
        chk("held.toggles", toggles, (20 + SYNC + 1) / (SYNC + 2));
        chk("held.dones", dones, 20 / (SYNC + 2));
        if (toggles % 2 == 1) exp_stim = ~exp_stim;
        chk("held.stim", int'(mif.stim), int'(exp_stim));
        idle(6);

        // Randomized path delays and modes
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 3))
                0: begin mode = 1; d = 0; end
                1: begin mode = 0; d = -1; end
                default: begin
                    k = $urandom_range(0, 6);
                    r = $urandom_range(1, 9);
                    d = k * TCLK + r;
                    vdly = d;
                    mode = 4;
                end
            endcase
            idle(6 + $urandom_range(0, 4));
            measure(d, $sformatf("rnd%0d_d%0d", n, d));
            idle(10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
